// File: rtl/counter_prescaler.sv
// Programmable tick prescaler: one-cycle ena every div+1 cycles while run is high, with a one-deep ratio update queue.
// Optional COUNTER_PRESCALER_SYNC_EN adds a sync input that restarts the current period.
module counter_prescaler #(
   parameter int WIDTH          = 16,
   parameter int IMPLEMENTATION = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
`ifdef COUNTER_PRESCALER_SYNC_EN
   input  logic             sync,
`endif
   input  logic             cfg_vld,
   input  logic [WIDTH-1:0] cfg_div,
   output logic             cfg_rdy,
   output logic             ena
);

   generate
      if (IMPLEMENTATION != 0 && IMPLEMENTATION != 1) begin : g_bad_impl
         $fatal(1, "counter_prescaler: IMPLEMENTATION must be 0 or 1");
      end
   endgenerate

   localparam bit               DOWN = (IMPLEMENTATION == 0);
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] div;
   logic [WIDTH-1:0] pnd_div;
   logic [WIDTH-1:0] phase;
   logic [WIDTH-1:0] div_apply;
   logic             pnd;
   logic             hs;
   logic             wrap;
   logic             sync_s;

`ifdef COUNTER_PRESCALER_SYNC_EN
   assign sync_s = sync;
`else
   assign sync_s = 1'b0;
`endif

   assign cfg_rdy   = !pnd;
   assign hs        = cfg_vld && cfg_rdy;
   assign div_apply = pnd ? pnd_div : div;
   // Down-counter ticks when it reaches 0; up-counter ticks when it reaches div.
   assign wrap      = DOWN ? (phase == '0) : (phase == div);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (run)  state_nxt = RUN;
         RUN:     if (!run) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div     <= '0;
         pnd_div <= '0;
         pnd     <= 1'b0;
         phase   <= '0;
         ena     <= 1'b0;
      end else begin
         ena <= 1'b0;
         if (state == IDLE) begin
            if (hs) div <= cfg_div;
            // Entering RUN: the first period already uses a ratio written on this edge.
            if (run && DOWN) phase <= hs ? cfg_div : div;
         end else if (!run) begin
            phase <= '0;
            if (pnd) begin
               div <= pnd_div;
               pnd <= 1'b0;
            end else if (hs) begin
               div <= cfg_div;
            end
         end else begin
            if (sync_s || wrap) begin
               ena   <= !sync_s;
               div   <= div_apply;
               phase <= DOWN ? div_apply : '0;
            end else begin
               phase <= DOWN ? (phase - ONE) : (phase + ONE);
            end
            // hs implies pnd was clear, so the pending slot is free to take the new ratio.
            if (hs) begin
               pnd     <= 1'b1;
               pnd_div <= cfg_div;
            end else if (sync_s || wrap) begin
               pnd <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_counter_prescaler.sv
// Self-checking bench for counter_prescaler: reference model feeds an expected-output queue, plus directed tick-pattern checks.
module tb_counter_prescaler;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic        cfg_vld;
   logic [15:0] cfg_div;
   logic        sync;
   logic        rdy0, ena0, rdy1, ena1;
   logic        run4, vld4;
   logic [3:0]  div4;
   logic        rdy2, ena2, rdy3, ena3;

   always #5 clk = ~clk;

   counter_prescaler #(.WIDTH(16), .IMPLEMENTATION(0)) u0 (
      .clk(clk), .rst(rst), .run(run),
`ifdef COUNTER_PRESCALER_SYNC_EN
      .sync(sync),
`endif
      .cfg_vld(cfg_vld), .cfg_div(cfg_div), .cfg_rdy(rdy0), .ena(ena0));

   counter_prescaler #(.WIDTH(16), .IMPLEMENTATION(1)) u1 (
      .clk(clk), .rst(rst), .run(run),
`ifdef COUNTER_PRESCALER_SYNC_EN
      .sync(sync),
`endif
      .cfg_vld(cfg_vld), .cfg_div(cfg_div), .cfg_rdy(rdy1), .ena(ena1));

   counter_prescaler #(.WIDTH(4), .IMPLEMENTATION(0)) u2 (
      .clk(clk), .rst(rst), .run(run4),
`ifdef COUNTER_PRESCALER_SYNC_EN
      .sync(1'b0),
`endif
      .cfg_vld(vld4), .cfg_div(div4), .cfg_rdy(rdy2), .ena(ena2));

   counter_prescaler #(.WIDTH(4), .IMPLEMENTATION(1)) u3 (
      .clk(clk), .rst(rst), .run(run4),
`ifdef COUNTER_PRESCALER_SYNC_EN
      .sync(1'b0),
`endif
      .cfg_vld(vld4), .cfg_div(div4), .cfg_rdy(rdy3), .ena(ena3));

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct packed {
      logic ena;
      logic rdy;
   } exp_t;

   exp_t sbq[$];
   bit   m_run;
   bit   m_pnd;
   int   m_div;
   int   m_pval;
   int   m_cnt;

   task automatic model_reset();
      m_run  = 1'b0;
      m_pnd  = 1'b0;
      m_div  = 0;
      m_pval = 0;
      m_cnt  = 0;
      sbq.delete();
   endtask

   task automatic apply_pending();
      if (m_pnd) begin
         m_div = m_pval;
         m_pnd = 1'b0;
      end
   endtask

   // Counts edges since the period start and predicts the registered outputs of the next edge.
   task automatic model_step(input logic r, input logic v, input int d, input logic s);
      bit   hs;
      exp_t e;
      hs    = v && !m_pnd;
      e.ena = 1'b0;
      if (!m_run) begin
         if (hs) m_div = d;
         if (r) begin
            m_run = 1'b1;
            m_cnt = 0;
         end
      end else if (!r) begin
         m_run = 1'b0;
         if (m_pnd) apply_pending();
         else if (hs) m_div = d;
      end else begin
         if (s) begin
            m_cnt = 0;
            apply_pending();
         end else begin
            m_cnt++;
            if (m_cnt == m_div + 1) begin
               e.ena = 1'b1;
               m_cnt = 0;
               apply_pending();
            end
         end
         if (hs) begin
            m_pnd  = 1'b1;
            m_pval = d;
         end
      end
      e.rdy = !m_pnd;
      sbq.push_back(e);
   endtask

   task automatic cyc(input logic r, input logic v, input int d, input logic s);
      exp_t e;
      run     = r;
      cfg_vld = v;
      cfg_div = d[15:0];
      sync    = s;
      model_step(r, v, d, s);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      chk("ena_u0", 32'(ena0), 32'(e.ena));
      chk("ena_u1", 32'(ena1), 32'(e.ena));
      chk("rdy_u0", 32'(rdy0), 32'(e.rdy));
      chk("rdy_u1", 32'(rdy1), 32'(e.rdy));
      cfg_vld = 1'b0;
      sync    = 1'b0;
   endtask

   logic [31:0] g0, g1, gr;

   initial begin
      rst = 1'b1; run = 1'b0; cfg_vld = 1'b0; cfg_div = '0; sync = 1'b0;
      run4 = 1'b0; vld4 = 1'b0; div4 = '0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("reset_ena_u0", 32'(ena0), 32'd0);
      chk("reset_rdy_u0", 32'(rdy0), 32'd1);
      chk("reset_ena_u1", 32'(ena1), 32'd0);
      chk("reset_rdy_u1", 32'(rdy1), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // Load 3 in IDLE, then run: ticks at E0+4, E0+8, E0+12.
      cyc(1'b0, 1'b1, 3, 1'b0);
      cyc(1'b1, 1'b0, 0, 1'b0);
      g0 = '0; g1 = '0;
      for (int k = 1; k <= 12; k++) begin
         cyc(1'b1, 1'b0, 0, 1'b0);
         g0[k-1] = ena0;
         g1[k-1] = ena1;
      end
      chk("ticks_div3_u0", g0, 32'h888);
      chk("ticks_div3_u1", g1, 32'h888);

      // Mid-period update to 1 waits in the pending slot until the next boundary.
      g0 = '0; g1 = '0; gr = '0;
      for (int k = 1; k <= 8; k++) begin
         cyc(1'b1, k == 2, 1, 1'b0);
         g0[k-1] = ena0;
         g1[k-1] = ena1;
         gr[k-1] = rdy0;
      end
      chk("ticks_pending_u0", g0, 32'h0A8);
      chk("ticks_pending_u1", g1, 32'h0A8);
      chk("rdy_pending_u0", gr, 32'h0F9);

      // Handshake exactly on a boundary edge applies one period later.
      cyc(1'b0, 1'b1, 3, 1'b0);
      cyc(1'b1, 1'b0, 0, 1'b0);
      g0 = '0; g1 = '0; gr = '0;
      for (int k = 1; k <= 12; k++) begin
         cyc(1'b1, k == 4, 0, 1'b0);
         g0[k-1] = ena0;
         g1[k-1] = ena1;
         gr[k-1] = rdy1;
      end
      chk("ticks_boundary_u0", g0, 32'hF88);
      chk("ticks_boundary_u1", g1, 32'hF88);
      chk("rdy_boundary_u1", gr, 32'hF87);

      // Asynchronous reset with a pending ratio outstanding.
      cyc(1'b1, 1'b1, 7, 1'b0);
      rst = 1'b1;
      #2;
      chk("arst_ena_u0", 32'(ena0), 32'd0);
      chk("arst_rdy_u0", 32'(rdy0), 32'd1);
      chk("arst_ena_u1", 32'(ena1), 32'd0);
      chk("arst_rdy_u1", 32'(rdy1), 32'd1);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("arst_hold_ena_u0", 32'(ena0), 32'd0);
      chk("arst_hold_rdy_u1", 32'(rdy1), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      cyc(1'b1, 1'b0, 0, 1'b0);
      g0 = '0; g1 = '0;
      for (int k = 1; k <= 5; k++) begin
         cyc(1'b1, 1'b0, 0, 1'b0);
         g0[k-1] = ena0;
         g1[k-1] = ena1;
      end
      chk("post_rst_div0_u0", g0, 32'h1F);
      chk("post_rst_div0_u1", g1, 32'h1F);

`ifdef COUNTER_PRESCALER_SYNC_EN
      // sync is ignored in IDLE, restarts the period in RUN.
      cyc(1'b0, 1'b1, 3, 1'b0);
      cyc(1'b0, 1'b0, 0, 1'b1);
      cyc(1'b1, 1'b0, 0, 1'b0);
      g0 = '0; g1 = '0;
      for (int k = 1; k <= 11; k++) begin
         cyc(1'b1, 1'b0, 0, k == 3);
         g0[k-1] = ena0;
         g1[k-1] = ena1;
      end
      chk("ticks_sync_u0", g0, 32'h440);
      chk("ticks_sync_u1", g1, 32'h440);
`endif

      for (int i = 0; i < 400; i++) begin
         logic r, v, s;
         int   d;
         r = ($urandom_range(0, 15) != 0);
         v = ($urandom_range(0, 3) == 0);
         d = int'($urandom_range(0, 4));
`ifdef COUNTER_PRESCALER_SYNC_EN
         s = ($urandom_range(0, 19) == 0);
`else
         s = 1'b0;
`endif
         cyc(r, v, d, s);
      end
      cyc(1'b0, 1'b0, 0, 1'b0);

      // All-ones ratio on a 4-bit instance: period of 16 cycles for both implementations.
      vld4 = 1'b1;
      div4 = 4'hF;
      @(posedge clk);
      #1;
      vld4 = 1'b0;
      run4 = 1'b1;
      @(posedge clk);
      #1;
      chk("w4_e0_ena_u2", 32'(ena2), 32'd0);
      for (int k = 1; k <= 48; k++) begin
         @(posedge clk);
         #1;
         chk("w4_ena_u2", 32'(ena2), 32'((k % 16) == 0));
         chk("w4_ena_u3", 32'(ena3), 32'((k % 16) == 0));
         chk("w4_rdy_u3", 32'(rdy3), 32'd1);
      end
      run4 = 1'b0;
      @(posedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/counter_prescaler.md
COUNTER_PRESCALER -- requirements
Module: counter_prescaler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the width of the division ratio and of the phase counter.
REQ-002 The block SHALL have parameter IMPLEMENTATION, default 0, meaning 0 = reloading down-counter, 1 = up-counter with compare; any other value SHALL abort elaboration with $fatal.
REQ-003 clk  input  1  clock; single clock domain, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 run  input  1  level enable; high = generate ticks, low = idle.
REQ-006 cfg_vld  input  1  new division ratio offered.
REQ-007 cfg_div  input  WIDTH  division ratio; tick period = cfg_div+1 cycles.
REQ-008 cfg_rdy  output  1  ratio can be accepted this cycle.
REQ-009 ena  output  1  registered single-cycle tick, drives the enable of a downstream wrapping counter.

Function
REQ-010 The block SHALL have states IDLE and RUN; IDLE->RUN on an edge sampling run=1, RUN->IDLE on an edge sampling run=0.
REQ-011 The block SHALL hold an active ratio register div and a one-entry pending register with valid flag pnd.
REQ-012 A handshake SHALL occur on an edge where cfg_vld=1 and cfg_rdy=1; cfg_rdy SHALL equal !pnd.
REQ-013 A handshake in IDLE, or on the edge that enters IDLE, SHALL write cfg_div directly into div; pnd SHALL stay 0.
REQ-014 A handshake in RUN SHALL store cfg_div into the pending register and set pnd.
REQ-015 If run is sampled high at edge E0, ena SHALL be registered high at edges E0+n*(div+1), n>=1, and low at all other edges while in RUN.
REQ-016 With div=0, ena SHALL be high on every cycle from E0+1 while run stays high.
REQ-017 At a period boundary (edge registering ena=1) with pnd=1 set before that edge, div SHALL take the pending value and pnd SHALL clear; the next period SHALL use the new div.
REQ-018 A handshake on a boundary edge SHALL only set pnd; its value SHALL apply at the following boundary.
REQ-019 An edge sampling run=0 SHALL register ena=0, clear the phase, and move any pending value into div with pnd cleared.
REQ-020 The phase counter SHALL never exceed div; IMPLEMENTATION 0 reloads div and ticks at 0; IMPLEMENTATION 1 counts from 0 and ticks at div, then returns to 0.
REQ-021 Both implementations SHALL produce identical ena and cfg_rdy sequences cycle for cycle.
REQ-022 The all-ones ratio (2^WIDTH-1) SHALL give a period of 2^WIDTH cycles without overflow of the phase counter.

Reset
REQ-023 While rst=1 the block SHALL hold state IDLE, div=0, phase=0, pnd=0, ena=0 and cfg_rdy=1, independent of clk.
REQ-024 rst asserted mid-period SHALL discard the current phase and any pending ratio; after rst is released, run high SHALL restart per REQ-015 using div=0 until a new ratio is accepted.

Configuration
REQ-025 Macro COUNTER_PRESCALER_SYNC_EN defined SHALL add input port sync (1 bit, after run). An edge sampling sync=1 in RUN SHALL clear the phase and register ena=0 at that edge. The next tick SHALL come div+1 edges later. Any pending ratio SHALL be applied at that edge. sync SHALL be ignored in IDLE.
REQ-026 Macro COUNTER_PRESCALER_SYNC_EN undefined SHALL remove port sync; all other behaviour SHALL be unchanged.

Verification
REQ-027 rst pulse mid-operation -> ena=0 and cfg_rdy=1 asynchronously; after release, run=1 -> ena high every cycle (div=0).
REQ-028 IDLE, load cfg_div=3, run=1 sampled at E0 -> ena high at E0+4, E0+8, E0+12 only.
REQ-029 RUN with div=3, load cfg_div=1 at E0+2 -> cfg_rdy=0 until E0+4; ticks at E0+4, E0+6, E0+8.
REQ-030 Handshake on boundary edge E0+4 (div=3, new value 0) -> next tick at E0+8, then every cycle.
REQ-031 WIDTH=4, cfg_div=15 -> ena period 16 cycles, identical for IMPLEMENTATION 0 and 1.
REQ-032 With COUNTER_PRESCALER_SYNC_EN, div=3, sync=1 at E0+3 -> no tick at E0+4; ticks at E0+7, E0+11.
